funnel_shifter_pipelined: RTL and testbench

FUNNEL_SHIFTER_PIPELINED -- requirements
Module: funnel_shifter_pipelined

---
 rtl/funnel_shifter_pipelined.sv | 159 +++++++++++++++
 tb/tb_funnel_shifter_pipelined.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/funnel_shifter_pipelined.sv
// Two-stage pipelined funnel shifter: LSR/ASR/ROR/ROL/LSL/ASL through one right-shifting funnel.
// Optional zero/carry flags are built when FUNNEL_SHIFTER_FLAGS_EN is defined.
module funnel_shifter_pipelined #(
    parameter  int WIDTH = 32,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SW-1:0]    shamt,
    input  logic [2:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef FUNNEL_SHIFTER_FLAGS_EN
    output logic             zero,
    output logic             carry,
`endif
    output logic [WIDTH-1:0] y
);

    if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("funnel_shifter_pipelined: WIDTH must be a power of two from 8 to 64");
    end

    localparam logic [SW:0] K_FULL = (SW + 1)'(WIDTH);

    // ROL and every left-shift encoding (1xx) shift right by WIDTH-shamt.
    function automatic logic is_left(input logic [2:0] ctl);
        return (ctl == 3'b011) || ctl[2];
    endfunction

    function automatic logic [2*WIDTH-1:0] funnel_pair(input logic [WIDTH-1:0] av,
                                                       input logic [2:0]       ctl);
        logic [2*WIDTH-1:0] pair;
        case (ctl)
            3'b000:         pair = {{WIDTH{1'b0}}, av};
            3'b001:         pair = {{WIDTH{av[WIDTH-1]}}, av};
            3'b010, 3'b011: pair = {av, av};
            default:        pair = {av, {WIDTH{1'b0}}};
        endcase
        return pair;
    endfunction

    function automatic logic [SW:0] right_count(input logic [SW-1:0] sv,
                                                input logic [2:0]    ctl);
        return is_left(ctl) ? (K_FULL - {1'b0, sv}) : {1'b0, sv};
    endfunction

    function automatic logic [WIDTH-1:0] funnel_shift(input logic [2*WIDTH-1:0] pair,
                                                      input logic [SW:0]        k);
        return WIDTH'(pair >> k);
    endfunction

`ifdef FUNNEL_SHIFTER_FLAGS_EN
    // Last bit shifted out; k==WIDTH (left) or k==0 (right) means shamt was zero.
    function automatic logic last_out(input logic [WIDTH-1:0] av,
                                      input logic [SW:0]      k,
                                      input logic             left);
        logic bit_out;
        if (left) begin
            bit_out = k[SW] ? 1'b0 : av[k[SW-1:0]];
        end else begin
            bit_out = (k == '0) ? 1'b0 : av[k[SW-1:0] - SW'(1)];
        end
        return bit_out;
    endfunction
`endif

    logic                 en;
    logic                 vld_p1_d, vld_p1_q;
    logic                 vld_p2_d, vld_p2_q;
    logic [2*WIDTH-1:0]   pair_p1_d, pair_p1_q;
    logic [SW:0]          k_p1_d, k_p1_q;
    logic [WIDTH-1:0]     y_p2_d, y_p2_q;
`ifdef FUNNEL_SHIFTER_FLAGS_EN
    logic [WIDTH-1:0]     a_p1_d, a_p1_q;
    logic                 left_p1_d, left_p1_q;
    logic                 zero_p2_d, zero_p2_q;
    logic                 carry_p2_d, carry_p2_q;
`endif

    always_comb begin
        en       = ~vld_p2_q | out_ready;
        in_ready = en;
        vld_p1_d = vld_p1_q;
        vld_p2_d = vld_p2_q;
        if (en) begin
            vld_p1_d = in_valid;
            vld_p2_d = vld_p1_q;
        end
    end

    // Stage 1: funnel pair and right-shift count
    always_comb begin
        pair_p1_d = pair_p1_q;
        k_p1_d    = k_p1_q;
`ifdef FUNNEL_SHIFTER_FLAGS_EN
        a_p1_d    = a_p1_q;
        left_p1_d = left_p1_q;
`endif
        if (en) begin
            pair_p1_d = funnel_pair(a, control);
            k_p1_d    = right_count(shamt, control);
`ifdef FUNNEL_SHIFTER_FLAGS_EN
            a_p1_d    = a;
            left_p1_d = is_left(control);
`endif
        end
    end

    // Stage 2: shifted result and flags
    always_comb begin
        y_p2_d = y_p2_q;
`ifdef FUNNEL_SHIFTER_FLAGS_EN
        zero_p2_d  = zero_p2_q;
        carry_p2_d = carry_p2_q;
`endif
        if (en) begin
            y_p2_d = funnel_shift(pair_p1_q, k_p1_q);
`ifdef FUNNEL_SHIFTER_FLAGS_EN
            zero_p2_d  = (funnel_shift(pair_p1_q, k_p1_q) == '0);
            carry_p2_d = last_out(a_p1_q, k_p1_q, left_p1_q);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
        end
    end

    // Data registers carry no reset; outputs are masked by the valid bit instead.
    always_ff @(posedge clk) begin
        pair_p1_q <= pair_p1_d;
        k_p1_q    <= k_p1_d;
        y_p2_q    <= y_p2_d;
`ifdef FUNNEL_SHIFTER_FLAGS_EN
        a_p1_q     <= a_p1_d;
        left_p1_q  <= left_p1_d;
        zero_p2_q  <= zero_p2_d;
        carry_p2_q <= carry_p2_d;
`endif
    end

    assign out_valid = vld_p2_q;
    assign y         = vld_p2_q ? y_p2_q : '0;
`ifdef FUNNEL_SHIFTER_FLAGS_EN
    assign zero      = vld_p2_q & zero_p2_q;
    assign carry     = vld_p2_q & carry_p2_q;
`endif

endmodule

// File: tb/tb_funnel_shifter_pipelined.sv
// Bench for funnel_shifter_pipelined (WIDTH=32): vector table, hand sequences, random vs model.
// Flag checks are compiled in when FUNNEL_SHIFTER_FLAGS_EN is defined.
module tb_funnel_shifter_pipelined;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [2:0]  control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
`ifdef FUNNEL_SHIFTER_FLAGS_EN
    logic        zero;
    logic        carry;
`endif

    funnel_shifter_pipelined #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .shamt(shamt),
        .control(control),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef FUNNEL_SHIFTER_FLAGS_EN
        .zero(zero),
        .carry(carry),
`endif
        .y(y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] y;
        logic        c;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  s;
        logic [2:0]  ctl;
        logic [31:0] y;
        logic        c;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[13];
    bit   rnd_done;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
        end
    endtask

    function automatic logic [31:0] model_y(input logic [31:0] av, input int s, input logic [2:0] ctl);
        logic [31:0] r;
        case (ctl)
            3'd0:    r = av >> s;
            3'd1:    r = $signed(av) >>> s;
            3'd2:    r = (s == 0) ? av : ((av >> s) | (av << (32 - s)));
            3'd3:    r = (s == 0) ? av : ((av << s) | (av >> (32 - s)));
            default: r = av << s;
        endcase
        return r;
    endfunction

    function automatic logic model_c(input logic [31:0] av, input int s, input logic [2:0] ctl);
        logic [31:0] r;
        logic        c;
        r = model_y(av, s, ctl);
        if (s == 0)                      c = 1'b0;
        else if (ctl == 3'd0 || ctl == 3'd1) c = av[s-1];
        else if (ctl == 3'd2)            c = r[31];
        else if (ctl == 3'd3)            c = r[0];
        else                             c = av[32-s];
        return c;
    endfunction

    task automatic send(input logic [31:0] av, input logic [4:0] sv, input logic [2:0] cv,
                        input logic [31:0] ey, input logic ec);
        int   n;
        exp_t e;
        a        = av;
        shamt    = sv;
        control  = cv;
        in_valid = 1'b1;
        n        = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) break;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            e.y = ey;
            e.c = ec;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every accepted result is matched in order; idle output must be zero.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", y, 32'hDEAD_BEEF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("y", y, mon_e.y);
`ifdef FUNNEL_SHIFTER_FLAGS_EN
                    check("zero", 32'(zero), 32'(mon_e.y == 32'd0));
                    check("carry", 32'(carry), 32'(mon_e.c));
`endif
                end
            end else if (!out_valid) begin
                check("idle_y", y, 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d tests expected completion", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [4:0]  rs;
        logic [2:0]  rc;

        vecs[0]  = '{32'h8000_0001, 5'd4,  3'b010, 32'h1800_0000, 1'b0};
        vecs[1]  = '{32'h8000_0000, 5'd31, 3'b001, 32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{32'h8000_0000, 5'd31, 3'b000, 32'h0000_0001, 1'b0};
        vecs[3]  = '{32'h1234_5678, 5'd8,  3'b011, 32'h3456_7812, 1'b0};
        vecs[4]  = '{32'h1234_5678, 5'd0,  3'b011, 32'h1234_5678, 1'b0};
        vecs[5]  = '{32'h8000_0000, 5'd1,  3'b100, 32'h0000_0000, 1'b1};
        vecs[6]  = '{32'h8000_0000, 5'd1,  3'b110, 32'h0000_0000, 1'b1};
        vecs[7]  = '{32'h0000_0001, 5'd4,  3'b111, 32'h0000_0010, 1'b0};
        vecs[8]  = '{32'h0000_000F, 5'd4,  3'b101, 32'h0000_00F0, 1'b0};
        vecs[9]  = '{32'h7FFF_FFF0, 5'd4,  3'b001, 32'h07FF_FFFF, 1'b0};
        vecs[10] = '{32'h0000_000F, 5'd1,  3'b000, 32'h0000_0007, 1'b1};
        vecs[11] = '{32'h0000_000F, 5'd0,  3'b010, 32'h0000_000F, 1'b0};
        vecs[12] = '{32'hF000_000F, 5'd0,  3'b001, 32'hF000_000F, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        shamt     = '0;
        control   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed table, applied back to back
        for (int i = 0; i < 13; i++) begin
            send(vecs[i].a, vecs[i].s, vecs[i].ctl, vecs[i].y, vecs[i].c);
        end
        drain();

        // Latency on an empty pipeline
        begin
            exp_t e;
            e.y = 32'h0000_000F;
            e.c = 1'b0;
            a = 32'h0000_00F0; shamt = 5'd4; control = 3'b000; in_valid = 1'b1;
            exp_q.push_back(e);
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            check("lat_early_valid", 32'(out_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("lat_valid", 32'(out_valid), 32'd1);
            check("lat_y", y, 32'h0000_000F);
            drain();
        end

        // Backpressure with three back-to-back inputs
        out_ready = 1'b0;
        fork
            begin
                send(32'h0000_00A5, 5'd4, 3'b000, 32'h0000_000A, 1'b0);
                send(32'h0000_0001, 5'd31, 3'b100, 32'h8000_0000, 1'b0);
                send(32'hC000_0003, 5'd1, 3'b010, 32'hE000_0001, 1'b1);
            end
            begin
                repeat (2) @(posedge clk);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_y", y, 32'h0000_000A);
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two results in flight
        send(32'h1111_1111, 5'd4, 3'b010, 32'h1111_1111, 1'b0);
        send(32'h2222_2222, 5'd8, 3'b011, 32'h2222_2222, 1'b0);
        reset    = 1'b1;
        in_valid = 1'b1;
        a        = 32'hFFFF_FFFF;
        shamt    = 5'd3;
        control  = 3'b100;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_y", y, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("post_rst_quiet", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Random traffic with random consumer stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    ra = $urandom();
                    case ($urandom_range(0, 5))
                        0:       rs = 5'd0;
                        1:       rs = 5'd31;
                        default: rs = 5'($urandom_range(0, 31));
                    endcase
                    rc = 3'($urandom_range(0, 7));
                    send(ra, rs, rc, model_y(ra, int'(rs), rc), model_c(ra, int'(rs), rc));
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
